// File: rtl/four_bit_add_pkg.sv
// Shared definitions for the registered ripple-carry adder.
// Consumers use the default width and the packed result type to carry
// a {carry-out, sum} pair through their own datapaths.
package four_bit_add_pkg;

    localparam int ADD_WIDTH = 4;

    typedef struct packed {
        logic                 cout;
        logic [ADD_WIDTH-1:0] sum;
    } add_result_t;

    // Packs a carry-out and sum into the shared result type.
    function automatic add_result_t pack_result(input logic cout, input logic [ADD_WIDTH-1:0] sum);
        add_result_t r;
        r.cout = cout;
        r.sum  = sum;
        return r;
    endfunction

endpackage

// File: rtl/four_bit_add_full_adder.sv
// Single-bit full-adder cell; the adder chains WIDTH of these.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Sum and carry of one bit position, carry propagates when a and b differ.
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (ci & (a ^ b));
    end

endmodule

// File: rtl/four_bit_add.sv
// Registered ripple-carry adder: {Cout, S} = A + B + Cin, one cycle latency.
// Optional status flags (zero, signed overflow) are built only when
// FOUR_BIT_ADD_FLAGS_EN is defined; otherwise those ports read constant 0.
module four_bit_add
    import four_bit_add_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             out_valid,
    output logic             zero,
    output logic             ovf
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;

    assign carry[0] = Cin;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_cell
            full_adder u_fa (
                .a  (A[i]),
                .b  (B[i]),
                .ci (carry[i]),
                .s  (sum_comb[i]),
                .co (carry[i+1])
            );
        end
    endgenerate

    // Result registers load only on accepted operands so idle inputs never reach S/Cout.
    always_ff @(posedge clk) begin
        if (rst) begin
            S    <= '0;
            Cout <= 1'b0;
        end else if (in_valid) begin
            S    <= sum_comb;
            Cout <= carry[WIDTH];
        end
    end

    // out_valid follows in_valid each cycle, so a result is flagged fresh exactly once.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

`ifdef FOUR_BIT_ADD_FLAGS_EN
    // Flags are registered alongside the sum; overflow is the carry into vs. out of the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero <= 1'b0;
            ovf  <= 1'b0;
        end else if (in_valid) begin
            zero <= (sum_comb == '0);
            ovf  <= carry[WIDTH] ^ carry[WIDTH-1];
        end
    end
`else
    assign zero = 1'b0;
    assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_four_bit_add.sv
// Self-checking bench for four_bit_add: directed cases, a full operand sweep
// and randomized traffic compared against an arithmetic reference model.
module tb_four_bit_add;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] A;
    logic [3:0] B;
    logic       Cin;
    logic [3:0] S;
    logic       Cout;
    logic       out_valid;
    logic       zero;
    logic       ovf;

    int checks_total;
    int checks_passed;

    int exp_s;
    int exp_cout;
    int exp_valid;
    int exp_zero;
    int exp_ovf;

    four_bit_add #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .S         (S),
        .Cout      (Cout),
        .out_valid (out_valid),
        .zero      (zero),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks_total++;
        if (observed == expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: observed %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the operands.
    task automatic modelStep(input bit r, input bit v, input int a, input int b, input int c);
        int total;
        int sa;
        int sb;
        int ssum;
        if (r) begin
            exp_s = 0; exp_cout = 0; exp_valid = 0; exp_zero = 0; exp_ovf = 0;
        end else begin
            exp_valid = v ? 1 : 0;
            if (v) begin
                total    = a + b + c;
                exp_s    = total % 16;
                exp_cout = (total >= 16) ? 1 : 0;
                sa       = (a >= 8) ? a - 16 : a;
                sb       = (b >= 8) ? b - 16 : b;
                ssum     = sa + sb + c;
`ifdef FOUR_BIT_ADD_FLAGS_EN
                exp_zero = (exp_s == 0) ? 1 : 0;
                exp_ovf  = (ssum > 7 || ssum < -8) ? 1 : 0;
`else
                exp_zero = 0;
                exp_ovf  = (ssum > 100) ? 1 : 0;
`endif
            end
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".S"},         int'(S),         exp_s);
        checkOutput({tag, ".Cout"},      int'(Cout),      exp_cout);
        checkOutput({tag, ".out_valid"}, int'(out_valid), exp_valid);
        checkOutput({tag, ".zero"},      int'(zero),      exp_zero);
        checkOutput({tag, ".ovf"},       int'(ovf),       exp_ovf);
    endtask

    // Drive one cycle of inputs at negedge, update the model, sample after the posedge.
    task automatic applyStimulus(input string tag, input bit r, input bit v,
                                 input int a, input int b, input int c, input bit drive_x);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        if (drive_x) begin
            A   = 'x;
            B   = 'x;
            Cin = 1'bx;
        end else begin
            A   = 4'(a);
            B   = 4'(b);
            Cin = 1'(c);
        end
        modelStep(r, v, a, b, c);
        @(posedge clk);
        #1;
        checkAll(tag);
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        exp_s = 0; exp_cout = 0; exp_valid = 0; exp_zero = 0; exp_ovf = 0;
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0;

        applyStimulus("reset", 1, 1, 15, 15, 1, 0);
        applyStimulus("reset2", 1, 1, 15, 15, 1, 0);

        applyStimulus("basic", 0, 1, 5, 3, 0, 0);
        applyStimulus("wrap", 0, 1, 15, 15, 1, 0);
        applyStimulus("eight", 0, 1, 8, 8, 0, 0);

        applyStimulus("load", 0, 1, 7, 6, 1, 0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus("hold", 0, 0, 1, 1, 0, 0);
        end
        for (int k = 0; k < 2; k++) begin
            applyStimulus("holdx", 0, 0, 0, 0, 0, 1);
        end

        applyStimulus("midop_load", 0, 1, 9, 4, 0, 0);
        applyStimulus("midop_rst", 1, 1, 3, 3, 1, 0);
        applyStimulus("after_rst", 0, 0, 2, 2, 0, 0);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    applyStimulus("sweep", 0, 1, a, b, c, 0);
                end
            end
        end

        for (int a = 0; a < 16; a++) begin
            applyStimulus("diag", 0, 1, a, a, a % 2, 0);
        end

        for (int k = 0; k < 200; k++) begin
            int v;
            v = int'($urandom_range(3, 0));
            if (v == 0) begin
                applyStimulus("rand_idle", 0, 0, 0, 0, 0, 1);
            end else begin
                applyStimulus("rand", 0, 1, int'($urandom_range(15, 0)),
                              int'($urandom_range(15, 0)), int'($urandom_range(1, 0)), 0);
            end
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/four_bit_add.md
# four_bit_add

Registered ripple-carry adder: adds two 4-bit operands plus a carry-in and presents the 4-bit sum and carry-out one clock after the operands are sampled. It is the arithmetic leaf used by datapath blocks that need a small synchronous adder with optional status flags. Outputs are always registered; no combinational path exists from inputs to outputs.

## Interface
- WIDTH, 4, operand/sum width in bits; legal range 1..16, default is the production configuration.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset; one clock, one reset, no other clock domains.
- in_valid  input  1  qualifies A, B, Cin this cycle.
- A  input  WIDTH  operand A, unsigned (two's complement for the overflow flag).
- B  input  WIDTH  operand B, same encoding as A.
- Cin  input  1  carry-in, weight 2^0.
- S  output  WIDTH  registered sum bits [WIDTH-1:0].
- Cout  output  1  registered carry-out, weight 2^WIDTH.
- out_valid  output  1  registered copy of in_valid; marks S/Cout/flags as a fresh result.
- zero  output  1  registered flag: S == 0 (flags feature).
- ovf  output  1  registered signed-overflow flag (flags feature).

## Operation
- Arithmetic: {Cout, S} = A + B + Cin, evaluated at full WIDTH+1 precision; never truncated beyond Cout.
- Sum built as a chain of WIDTH full-adder cells: s_i = a_i ^ b_i ^ c_i; c_{i+1} = a_i&b_i | c_i&(a_i^b_i); c_0 = Cin; Cout = c_WIDTH.
- Result registers load on every rising clk edge where in_valid = 1; when in_valid = 0, S, Cout, zero and ovf hold their previous values.
- out_valid registers in_valid every cycle (1 for exactly one cycle per accepted operand set).
- zero = 1 when the loaded S is all zeros, independent of Cout (e.g. 8+8 at WIDTH=4 gives S=0, Cout=1, zero=1).
- ovf = c_WIDTH ^ c_{WIDTH-1}: set when A and B have equal MSB and S MSB differs.
- Wrap-around: 15+15+1 at WIDTH=4 gives S=15, Cout=1; no saturation.
- X/Z on inputs when in_valid = 0 must not disturb registered outputs.

## Timing
- Latency 1 cycle: operands sampled at edge N appear on S/Cout/flags/out_valid after edge N; throughput one result per cycle.
- Reset: when rst = 1 at a clock edge, S = 0, Cout = 0, zero = 0, ovf = 0, out_valid = 0 after that edge, overriding in_valid.
- Reset mid-operation: an operand set sampled in the same cycle as rst is discarded; no result emerges after rst deasserts until a new in_valid.
- Combinational carry chain is WIDTH cells deep; must close timing at the datapath clock for WIDTH = 4.

## Configuration
- FOUR_BIT_ADD_FLAGS_EN defined: zero and ovf computed and registered as above.
- Not defined: zero and ovf ports remain present but are tied to constant 0; no flag logic or flag registers are synthesized. S, Cout, out_valid unaffected.

## Structure
- Shared package holds: default width constant (ADD_WIDTH = 4) and a packed result typedef {cout, sum[WIDTH-1:0]} used by consumers.
- One sub-module: full_adder (inputs a, b, ci; outputs s, co), instantiated WIDTH times in a generate loop; top level owns only registers and flag logic.

## Test plan
- Reset: drive rst = 1 with in_valid = 1, A = 4'hF, B = 4'hF, Cin = 1 -> after edge S = 0, Cout = 0, out_valid = 0, zero = 0, ovf = 0.
- Basic: A = 5, B = 3, Cin = 0, in_valid = 1 -> next cycle S = 8, Cout = 0, out_valid = 1, ovf = 1 (flags on), zero = 0.
- Carry/wrap: A = 15, B = 15, Cin = 1 -> S = 15, Cout = 1; A = 8, B = 8, Cin = 0 -> S = 0, Cout = 1, zero = 1, ovf = 1.
- Hold: one result loaded, then in_valid = 0 with A = 1, B = 1 for 3 cycles -> S/Cout unchanged, out_valid = 0.
- Exhaustive: sweep all 512 (A, B, Cin) combinations (including the A = B counting pattern with Cin toggling every vector) -> each result equals A + B + Cin one cycle later.
- Flags off build: repeat Basic and Carry/wrap without FOUR_BIT_ADD_FLAGS_EN -> same S/Cout, zero = 0 and ovf = 0 throughout.
